// File: rtl/stack_eval_unit.sv
// stack_eval_unit
// Expression-evaluation controller and datapath sitting between an external
// operand stack and an external operator stack. On start it repeatedly pops
// an operator and two operands, computes the result and pushes it back onto
// the operand stack. It stops when the operator stack is empty, or earlier
// on an error, and signals the end of the run with a one-cycle complete
// pulse.
//
// Parameters:
//   W   - operand/result width in bits
//   OPW - operator code width (ASCII '+','-','*','/' zero-extended)
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-low
//   start      - begin a run (sampled in IDLE only)
//   opnd_empty - operand stack empty
//   op_empty   - operator stack empty
//   opnd_dout  - operand top-of-stack (valid while not empty)
//   op_dout    - operator top-of-stack (valid while not empty)
//   opnd_pop   - pop operand stack at this edge
//   opnd_push  - push opnd_din at this edge
//   opnd_din   - value to push
//   op_pop     - pop operator stack at this edge
//   result     - final value, held until the next start
//   busy       - high whenever not IDLE
//   complete   - one-cycle end-of-run pulse
//   err        - run ended in error (valid with complete, held)
//   err_code   - 00 none, 01 underflow, 10 divide by zero, 11 bad opcode
//   ovf        - sticky arithmetic overflow/underflow flag
//
// Configuration macro:
//   STACK_EVAL_SAT_EN - when defined, '+'/'*' saturate to all-ones and '-'
//                       clamps to zero on borrow; otherwise arithmetic wraps.
module stack_eval_unit #(
  parameter int W   = 8,
  parameter int OPW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           opnd_empty,
  input  logic           op_empty,
  input  logic [W-1:0]   opnd_dout,
  input  logic [OPW-1:0] op_dout,
  output logic           opnd_pop,
  output logic           opnd_push,
  output logic [W-1:0]   opnd_din,
  output logic           op_pop,
  output logic [W-1:0]   result,
  output logic           busy,
  output logic           complete,
  output logic           err,
  output logic [1:0]     err_code,
  output logic           ovf
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(8'h2B);
  localparam logic [OPW-1:0] OP_SUB = OPW'(8'h2D);
  localparam logic [OPW-1:0] OP_MUL = OPW'(8'h2A);
  localparam logic [OPW-1:0] OP_DIV = OPW'(8'h2F);

  typedef enum logic [2:0] {
    IDLE, CHECK, POP_B, POP_A, POP_OP, EXEC, PUSH, DONE
  } state_t;

  state_t         state, next_state;
  logic [W-1:0]   a, b, r;
  logic [OPW-1:0] op;
  logic           processed;
  logic           err_set;
  logic [1:0]     err_val;

  logic [W:0]     sum, diff;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   alu_r;
  logic           alu_ovf;
  logic           op_legal;

  assign opnd_din = r;
  assign err      = |err_code;

  // Raw arithmetic is evaluated in extended width so carry, borrow and the
  // upper product half are available for overflow detection. The divider is
  // guarded so a zero divisor never reaches it.
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};
  assign prod     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign quo      = (b == '0) ? '0 : a / b;
  assign op_legal = (op == OP_ADD) || (op == OP_SUB) ||
                    (op == OP_MUL) || (op == OP_DIV);

  // Result selection for the latched operator; a is the left operand since
  // the first value popped (b) is the right-hand side of the expression.
  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_r   = sum[W-1:0];
        alu_ovf = sum[W];
`ifdef STACK_EVAL_SAT_EN
        if (sum[W]) alu_r = '1;
`endif
      end
      OP_SUB: begin
        alu_r   = diff[W-1:0];
        alu_ovf = diff[W];
`ifdef STACK_EVAL_SAT_EN
        if (diff[W]) alu_r = '0;
`endif
      end
      OP_MUL: begin
        alu_r   = prod[W-1:0];
        alu_ovf = |prod[2*W-1:W];
`ifdef STACK_EVAL_SAT_EN
        if (|prod[2*W-1:W]) alu_r = '1;
`endif
      end
      OP_DIV: begin
        alu_r = quo;
      end
      default: begin
        alu_r = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and stack strobes. Strobes depend only on the current state,
  // plus the empty flag in the pop states so an empty stack is never popped.
  always_comb begin
    next_state = state;
    opnd_pop   = 1'b0;
    opnd_push  = 1'b0;
    op_pop     = 1'b0;
    complete   = 1'b0;
    busy       = (state != IDLE);
    err_set    = 1'b0;
    err_val    = 2'b00;
    case (state)
      IDLE: begin
        if (start) next_state = CHECK;
      end
      CHECK: begin
        if (op_empty) begin
          if (opnd_empty) begin
            err_set = 1'b1;
            err_val = 2'b01;
          end
          next_state = DONE;
        end else begin
          next_state = POP_B;
        end
      end
      POP_B, POP_A: begin
        if (opnd_empty) begin
          err_set    = 1'b1;
          err_val    = 2'b01;
          next_state = DONE;
        end else begin
          opnd_pop   = 1'b1;
          next_state = (state == POP_B) ? POP_A : POP_OP;
        end
      end
      POP_OP: begin
        op_pop     = 1'b1;
        next_state = EXEC;
      end
      EXEC: begin
        if ((op == OP_DIV) && (b == '0)) begin
          err_set    = 1'b1;
          err_val    = 2'b10;
          next_state = DONE;
        end else if (!op_legal) begin
          err_set    = 1'b1;
          err_val    = 2'b11;
          next_state = DONE;
        end else begin
          next_state = PUSH;
        end
      end
      PUSH: begin
        opnd_push  = 1'b1;
        next_state = CHECK;
      end
      DONE: begin
        complete   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers. 'processed' remembers whether any operator ran in
  // this run, so an operator-free run reports the operand top as its result
  // while a finished multi-operator run keeps the last pushed value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a         <= '0;
      b         <= '0;
      r         <= '0;
      op        <= '0;
      result    <= '0;
      err_code  <= 2'b00;
      ovf       <= 1'b0;
      processed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_code  <= 2'b00;
            ovf       <= 1'b0;
            processed <= 1'b0;
          end
        end
        CHECK: begin
          if (op_empty && !opnd_empty && !processed) result <= opnd_dout;
        end
        POP_B:  if (!opnd_empty) b <= opnd_dout;
        POP_A:  if (!opnd_empty) a <= opnd_dout;
        POP_OP: op <= op_dout;
        EXEC: begin
          if (next_state == PUSH) begin
            r   <= alu_r;
            ovf <= ovf | alu_ovf;
          end
        end
        PUSH: begin
          result    <= r;
          processed <= 1'b1;
        end
        default: ;
      endcase
      if (err_set) err_code <= err_val;
    end
  end

endmodule

// File: tb/tb_stack_eval_unit.sv
// Testbench for stack_eval_unit: models both external stacks as queues,
// drives directed and random expressions, and compares the DUT against a
// queue-based evaluator of the same expression.
module tb_stack_eval_unit;

  localparam int W   = 8;
  localparam int OPW = 8;
`ifdef STACK_EVAL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           clk, reset, start, opnd_empty, op_empty;
  logic [W-1:0]   opnd_dout;
  logic [OPW-1:0] op_dout;
  logic           opnd_pop, opnd_push, op_pop, busy, complete, err, ovf;
  logic [W-1:0]   opnd_din, result;
  logic [1:0]     err_code;

  stack_eval_unit #(.W(W), .OPW(OPW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .opnd_empty(opnd_empty), .op_empty(op_empty),
    .opnd_dout(opnd_dout), .op_dout(op_dout),
    .opnd_pop(opnd_pop), .opnd_push(opnd_push), .opnd_din(opnd_din),
    .op_pop(op_pop), .result(result), .busy(busy), .complete(complete),
    .err(err), .err_code(err_code), .ovf(ovf)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]   opnd_q[$];
  logic [OPW-1:0] op_q[$];
  logic [W-1:0]   din_q[$];
  logic [OPW-1:0] dop_q[$];

  int n_compared = 0;
  int n_mismatch = 0;

  logic           s_complete, s_busy, s_err, s_ovf;
  logic [1:0]     s_code;
  logic [W-1:0]   s_result;
  int             op_pops, excl_viol;

  logic           d_busy, d_err, d_ovf;
  logic [1:0]     d_code;
  logic [W-1:0]   d_result;
  int             d_cycle;

  logic [W-1:0]   exp_result;
  int             exp_code, exp_cycles, exp_op_remain, exp_op_pops;
  bit             exp_ovf;
  logic [W-1:0]   exp_stk[$];
  logic [W-1:0]   prev_result;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_compared++;
    assert (obs === expv) else begin
      n_mismatch++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic refreshStacks();
    opnd_empty = (opnd_q.size() == 0);
    opnd_dout  = opnd_empty ? '0 : opnd_q[opnd_q.size()-1];
    op_empty   = (op_q.size() == 0);
    op_dout    = op_empty ? '0 : op_q[op_q.size()-1];
  endtask

  // Sample the settled cycle, cross the rising edge, then let the stacks
  // act on the strobes that were high during that cycle.
  task automatic stepCycle();
    logic           pb, pu, po;
    logic [W-1:0]   dv, tv;
    logic [OPW-1:0] to;
    #1;
    s_complete = complete; s_busy = busy; s_err = err;
    s_ovf = ovf; s_code = err_code; s_result = result;
    pb = opnd_pop; pu = opnd_push; po = op_pop; dv = opnd_din;
    if ((int'(pb) + int'(pu) + int'(po)) > 1) excl_viol++;
    @(posedge clk);
    #1;
    if (pb && opnd_q.size() > 0) tv = opnd_q.pop_back();
    if (pu) opnd_q.push_back(dv);
    if (po && op_q.size() > 0) begin
      to = op_q.pop_back();
      op_pops++;
    end
    refreshStacks();
  endtask

  // Reference evaluator: walks the expression with queues and plain
  // integer arithmetic, tallying the cycle cost of each step.
  task automatic modelRun();
    int unsigned    mask;
    int unsigned    a, b, v;
    logic [OPW-1:0] ops[$];
    logic [OPW-1:0] o;
    bit             done, processed;
    mask = (1 << W) - 1;
    done = 0; processed = 0; v = 0;
    exp_stk = din_q; ops = dop_q;
    exp_result = prev_result; exp_code = 0; exp_ovf = 0;
    exp_cycles = 0; exp_op_pops = 0;
    while (!done) begin
      if (ops.size() == 0) begin
        if (exp_stk.size() == 0) exp_code = 1;
        else if (!processed) exp_result = exp_stk[exp_stk.size()-1];
        exp_cycles += 2; done = 1;
      end else if (exp_stk.size() == 0) begin
        exp_code = 1; exp_cycles += 3; done = 1;
      end else begin
        b = exp_stk.pop_back();
        if (exp_stk.size() == 0) begin
          exp_code = 1; exp_cycles += 4; done = 1;
        end else begin
          a = exp_stk.pop_back();
          o = ops.pop_back();
          exp_op_pops++;
          exp_cycles += 6;
          if (o == 8'h2F && b == 0) begin
            exp_code = 2; done = 1;
          end else if (o == 8'h2B) begin
            v = a + b;
            if (v > mask) begin exp_ovf = 1; v = SAT ? mask : v - (mask + 1); end
          end else if (o == 8'h2D) begin
            if (a < b) begin exp_ovf = 1; v = SAT ? 0 : a + (mask + 1) - b; end
            else v = a - b;
          end else if (o == 8'h2A) begin
            v = a * b;
            if (v > mask) begin exp_ovf = 1; v = SAT ? mask : v % (mask + 1); end
          end else if (o == 8'h2F) begin
            v = a / b;
          end else begin
            exp_code = 3; done = 1;
          end
          if (!done) begin
            exp_stk.push_back(v[W-1:0]);
            exp_result = v[W-1:0];
            processed = 1;
          end
        end
      end
    end
    exp_op_remain = ops.size();
  endtask

  // One complete run: load stacks, start, wait (bounded) for complete,
  // then compare everything the reference model predicts.
  task automatic applyStimulus(input string name);
    int seen;
    bit ok;
    seen = 0; d_cycle = 0;
    opnd_q = din_q; op_q = dop_q; refreshStacks();
    modelRun();
    op_pops = 0; excl_viol = 0;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int c = 1; c <= 100 && seen == 0; c++) begin
      stepCycle();
      if (s_complete) begin
        seen = c;
        d_busy = s_busy; d_err = s_err; d_ovf = s_ovf;
        d_code = s_code; d_result = s_result;
      end
    end
    d_cycle = seen;
    stepCycle();
    checkOutput({name, ".complete_cycle"}, seen, exp_cycles);
    checkOutput({name, ".result"}, d_result, exp_result);
    checkOutput({name, ".err"}, d_err, (exp_code != 0));
    checkOutput({name, ".err_code"}, d_code, exp_code);
    checkOutput({name, ".ovf"}, d_ovf, exp_ovf);
    checkOutput({name, ".busy_at_done"}, d_busy, 1);
    checkOutput({name, ".single_pulse"}, s_complete, 0);
    checkOutput({name, ".idle_after"}, s_busy, 0);
    checkOutput({name, ".stack_size"}, opnd_q.size(), exp_stk.size());
    ok = (opnd_q.size() == exp_stk.size());
    if (ok) for (int i = 0; i < opnd_q.size(); i++) if (opnd_q[i] !== exp_stk[i]) ok = 0;
    checkOutput({name, ".stack_contents"}, ok, 1);
    checkOutput({name, ".op_remain"}, op_q.size(), exp_op_remain);
    checkOutput({name, ".op_pops"}, op_pops, exp_op_pops);
    checkOutput({name, ".strobe_exclusive"}, excl_viol, 0);
    prev_result = exp_result;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0;
    opnd_q = {}; op_q = {}; refreshStacks();
    prev_result = '0; op_pops = 0; excl_viol = 0;
    stepCycle();
    stepCycle();
    #1;
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.complete", complete, 0);
    checkOutput("rst.result", result, 0);
    checkOutput("rst.err_code", err_code, 0);
    checkOutput("rst.err", err, 0);
    checkOutput("rst.ovf", ovf, 0);
    checkOutput("rst.opnd_din", opnd_din, 0);
    checkOutput("rst.strobes", {opnd_pop, opnd_push, op_pop}, 0);
    reset = 1'b1;
    stepCycle();

    din_q = {8'd3, 8'd4}; dop_q = {8'h2B};
    applyStimulus("tp_add");
    checkOutput("tp_add.result_lit", d_result, 7);
    checkOutput("tp_add.cycle_lit", d_cycle, 8);

    din_q = {8'd3, 8'd4}; dop_q = {8'h2D};
    applyStimulus("tp_sub");
    checkOutput("tp_sub.result_lit", d_result, SAT ? 0 : 255);

    din_q = {8'd2, 8'd3, 8'd4}; dop_q = {8'h2B, 8'h2A};
    applyStimulus("tp_chain");
    checkOutput("tp_chain.result_lit", d_result, 14);
    checkOutput("tp_chain.cycle_lit", d_cycle, 14);

    din_q = {8'd8, 8'd0}; dop_q = {8'h2F};
    applyStimulus("tp_div0");
    checkOutput("tp_div0.code_lit", d_code, 2);
    checkOutput("tp_div0.cycle_lit", d_cycle, 6);

    din_q = {8'd5}; dop_q = {8'h2B};
    applyStimulus("tp_underflow");
    checkOutput("tp_underflow.code_lit", d_code, 1);

    din_q = {8'd9}; dop_q = {};
    applyStimulus("tp_zero_ops");

    din_q = {8'd1, 8'd2}; dop_q = {8'h25};
    applyStimulus("tp_badop");

    // Reset asserted while the second operand is being popped.
    din_q = {8'd3, 8'd4}; dop_q = {8'h2B};
    opnd_q = din_q; op_q = dop_q; refreshStacks();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    stepCycle();
    #1;
    checkOutput("midrst.busy", busy, 0);
    checkOutput("midrst.complete", complete, 0);
    checkOutput("midrst.result", result, 0);
    reset = 1'b1;
    opnd_q = {}; op_q = {}; refreshStacks();
    prev_result = '0;
    stepCycle();

    din_q = {8'd6, 8'd7}; dop_q = {8'h2A};
    applyStimulus("after_rst");

    for (int i = 0; i < 40; i++) begin
      int nv, no, sel;
      logic [OPW-1:0] optab[4];
      optab[0] = 8'h2B; optab[1] = 8'h2D; optab[2] = 8'h2A; optab[3] = 8'h2F;
      nv = $urandom_range(0, 5);
      no = $urandom_range(0, 4);
      din_q = {}; dop_q = {};
      for (int j = 0; j < nv; j++)
        din_q.push_back(($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255)));
      for (int j = 0; j < no; j++) begin
        sel = $urandom_range(0, 9);
        dop_q.push_back((sel == 9) ? OPW'(8'h25) : optab[sel % 4]);
      end
      applyStimulus($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/stack_eval_unit.md
# stack_eval_unit

Parametrised expression-evaluation controller and datapath. On `start` it repeatedly pops an operator and two operands from the external operator and operand stacks, computes the result, and pushes it back until the operator stack is empty. It then reports the final value with a one-cycle `complete` pulse. Compared with the previous 8-bit single-operation calculator, it adds configurable width, multi-operator runs, underflow, divide-by-zero and opcode error detection, and overflow reporting.

## Interface
- `W`, 8: operand/result width in bits.
- `OPW`, 8: operator code width; codes are ASCII '+'=8'h2B, '-'=8'h2D, '*'=8'h2A, '/'=8'h2F, zero-extended to OPW.
- `clk` in 1: single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: request evaluation; sampled only in IDLE.
- `opnd_empty` in 1: operand stack empty.
- `op_empty` in 1: operator stack empty.
- `opnd_dout` in W: operand top-of-stack; combinationally valid while not empty.
- `op_dout` in OPW: operator top-of-stack; combinationally valid while not empty.
- `opnd_pop` out 1: pop the operand stack at this edge.
- `opnd_push` out 1: push `opnd_din` at this edge.
- `opnd_din` out W: value to push.
- `op_pop` out 1: pop the operator stack at this edge.
- `result` out W: final value, held until the next start.
- `busy` out 1: high in every state except IDLE.
- `complete` out 1: one-cycle pulse at end of run, success or error.
- `err` out 1: run ended in error; valid with `complete` and held until the next start.
- `err_code` out 2: 00 none, 01 operand underflow, 10 divide by zero, 11 illegal opcode.
- `ovf` out 1: sticky; set when any operation overflows or underflows W bits; cleared on accepted start.

## Operation
- States: IDLE, CHECK, POP_B, POP_A, POP_OP, EXEC, PUSH, DONE.
- IDLE: if `start`, clear `err`/`err_code`/`ovf` and go to CHECK. `start` in any other state is ignored.
- CHECK, operator stack empty:
  - Operand stack not empty: if no operator was processed this run, `result` <= `opnd_dout` (peek, no pop); go to DONE.
  - Operand stack empty: underflow error; go to DONE.
- CHECK, operator stack not empty: go to POP_B.
- POP_B:
  - `opnd_empty`: underflow error, go to DONE.
  - Otherwise: b <= `opnd_dout`, `opnd_pop`=1, go to POP_A.
- POP_A: same as POP_B, latching a. An underflow here leaves b consumed; no restore.
- POP_OP: op <= `op_dout`, `op_pop`=1.
- EXEC: r <= a op b; first-popped value is the right operand.
  - '+': a+b.
  - '-': a-b, unsigned.
  - '*': low W bits of a*b.
  - '/': floor(a/b).
  - b==0 on '/': err_code 10, go to DONE, no push.
  - Unknown op: err_code 11, go to DONE.
- PUSH: `opnd_din`=r, `opnd_push`=1, `result` <= r, go to CHECK.
- DONE: `complete`=1; `err`=1 if `err_code`!=0; go to IDLE.
- `opnd_pop`, `opnd_push` and `op_pop` are Moore outputs and mutually exclusive.
- Overflow conditions: carry out of '+', borrow on '-', nonzero upper product bits on '*'.

## Timing
- Reset (`reset`=0 at an edge): state IDLE; all outputs 0, including `result`, `err_code`, `ovf` and `opnd_din`. Reset mid-run aborts with no `complete` pulse; stack contents are not repaired.
- With start accepted at edge k, the run occupies cycles k+1 onward.
- Per operator: 6 cycles (CHECK, POP_B, POP_A, POP_OP, EXEC, PUSH).
- Successful run with N≥1 operators: `complete` high in cycle 2+6N after start.
- Zero-operator run: `complete` high in cycle 2.
- Stack handshake: a pop or push strobe is exactly one cycle. The stack updates at the end of that cycle, and the new top is valid in the next state.

## Configuration
- `STACK_EVAL_SAT_EN` defined:
  - '+' and '*' overflow saturate to all-ones.
  - '-' borrow clamps to 0.
  - `ovf` still sets.
- `STACK_EVAL_SAT_EN` not defined: all arithmetic wraps modulo 2^W; `ovf` sets identically.

## Test plan
- W=8, operands 3,4 (4 on top), op '+'; `start` at k → `opnd_pop` twice, `op_pop` once, push 7, `result`=7, `complete` at cycle k+8, `err`=0.
- Operands 3,4 (4 on top), op '-' → `ovf`=1; `result`=255 without macro, 0 with `STACK_EVAL_SAT_EN`.
- Operands 2,3,4 (4 on top), ops '*' on top then '+' → pushes 12 then 14; `result`=14; `complete` at k+14.
- Operands 8,0 (0 on top), op '/' → `err`=1, `err_code`=10, no `opnd_push`, `complete` at k+6.
- Single operand 5, op '+' → one `opnd_pop`, `err_code`=01; `op_pop` never asserted.
- `reset`=0 during POP_A → next cycle `busy`=0, `complete`=0, `result`=0; a new start evaluates normally.
